// File: rtl/pipe_trace_pkg.sv
// Shared definitions for the commit-trace buffer: FSM states, capture modes and
// the entry layout {pc, instr, wb_data, rwd} (rwd in the LSBs).
package pipe_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_POST = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic MODE_LINEAR = 1'b0;
  localparam logic MODE_RING   = 1'b1;

  // Total width of one captured entry.
  function automatic int unsigned entry_w(input int unsigned dw, input int unsigned aw);
    return 3 * dw + aw;
  endfunction

  // LSB positions of each field inside an entry / rd_data.
  function automatic int unsigned rwd_lsb();
    return 0;
  endfunction

  function automatic int unsigned wb_lsb(input int unsigned aw);
    return aw;
  endfunction

  function automatic int unsigned instr_lsb(input int unsigned dw, input int unsigned aw);
    return dw + aw;
  endfunction

  function automatic int unsigned pc_lsb(input int unsigned dw, input int unsigned aw);
    return 2 * dw + aw;
  endfunction

endpackage

// File: rtl/pipe_trace_buffer_ram.sv
// Trace storage: DEPTH x W register array, one synchronous write port and one
// asynchronous read port.
//  clk   in  clock
//  we    in  write enable
//  waddr in  write address
//  wdata in  write data
//  raddr in  read address
//  rdata out read data (combinational)
module trace_ram #(
  parameter int unsigned W     = 101,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned PW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Write port; storage needs no reset, reads are qualified by the controller.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Commit-trace capture buffer. Records the per-commit debug bus in LINEAR
// (fill until full) or RING (wrap until a PC trigger plus a post window) mode,
// then drains oldest-first over a valid/ready port.
//  clk, rst_n             clock, synchronous active-low reset
//  commit_*               commit debug bus (valid, pc, instr, wb_data, rwd)
//  arm, mode, trig_pc     start capture; mode/trig_pc latched on arm
//  rd_valid/rd_ready      drain handshake, rd_data = {pc, instr, wb_data, rwd}
//  count                  entries held
//  triggered, overflow    sticky ring flags
//  busy                   capture in progress
module pipe_trace_buffer
  import pipe_trace_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 5,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 4,
  localparam int unsigned EW       = entry_w(DW, AW),
  localparam int unsigned PW       = $clog2(DEPTH),
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          commit_valid,
  input  logic [DW-1:0] commit_pc,
  input  logic [DW-1:0] commit_instr,
  input  logic [DW-1:0] commit_wb_data,
  input  logic [AW-1:0] commit_rwd,
  input  logic          arm,
  input  logic          mode,
  input  logic [DW-1:0] trig_pc,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [EW-1:0] rd_data,
  output logic [CW-1:0] count,
  output logic          triggered,
  output logic          overflow,
  output logic          busy
);

  // Last post-trigger index; only meaningful when POST_TRIG > 0.
  localparam logic [PW-1:0] PT_LAST = PW'((POST_TRIG == 0) ? 0 : POST_TRIG - 1);

  state_t        state;
  logic          mode_q;
  logic [DW-1:0] trig_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] post_cnt;
  logic          full;
  logic          wr_en;
  logic          pop;

  assign busy     = (state == ST_PRE) || (state == ST_POST);
  assign rd_valid = (state == ST_DONE) && (count != '0);
  assign full     = (count == CW'(DEPTH));
  // arm wins over both capture and pop in the same cycle.
  assign wr_en    = commit_valid && busy && !arm;
  assign pop      = rd_valid && rd_ready && !arm;

  trace_ram #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata ({commit_pc, commit_instr, commit_wb_data, commit_rwd}),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Control FSM, pointers, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_LINEAR;
      trig_q    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else if (arm) begin
      state     <= ST_PRE;
      mode_q    <= mode;
      trig_q    <= trig_pc;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      post_cnt  <= '0;
      count     <= '0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ST_PRE, ST_POST: begin
          if (commit_valid) begin
            wr_ptr <= wr_ptr + PW'(1);
            // A full ring drops its oldest entry; count saturates.
            if (mode_q == MODE_RING && full) begin
              rd_ptr   <= rd_ptr + PW'(1);
              overflow <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
            if (mode_q == MODE_LINEAR) begin
              if (count == CW'(DEPTH - 1)) begin
                state <= ST_DONE;
              end
            end else if (state == ST_PRE) begin
              if (commit_pc == trig_q) begin
                triggered <= 1'b1;
                post_cnt  <= '0;
                state     <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
              end
            end else begin
              post_cnt <= post_cnt + PW'(1);
              if (post_cnt == PT_LAST) begin
                state <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            count  <= count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Randomized scoreboard bench for pipe_trace_buffer (DEPTH=8, POST_TRIG=2).
// The reference model keeps the captured record as a plain queue; a negedge
// monitor pops it on every drain handshake and compares rd_data.
module tb_pipe_trace_buffer;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 8;
  localparam int POST_TRIG = 2;
  localparam int EW = 3 * DW + AW;
  localparam int CW = $clog2(DEPTH + 1);

  typedef logic [EW-1:0] entry_t;

  logic clk = 1'b0;
  logic rst_n;
  logic commit_valid;
  logic [DW-1:0] commit_pc, commit_instr, commit_wb_data;
  logic [AW-1:0] commit_rwd;
  logic arm, mode;
  logic [DW-1:0] trig_pc;
  logic rd_valid, rd_ready;
  logic [EW-1:0] rd_data;
  logic [CW-1:0] count;
  logic triggered, overflow, busy;

  int n_cmp = 0;
  int n_bad = 0;

  pipe_trace_buffer #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_instr(commit_instr),
    .commit_wb_data(commit_wb_data), .commit_rwd(commit_rwd),
    .arm(arm), .mode(mode), .trig_pc(trig_pc),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .triggered(triggered), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: what the buffer should hold, by the capture rules.
  entry_t     mq[$];
  bit         m_armed, m_busy, m_mode, m_trg, m_ovf, m_in_post;
  int         m_post_left;
  logic [DW-1:0] m_trig;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_armed = 0; m_busy = 0; m_mode = 0; m_trg = 0; m_ovf = 0; m_in_post = 0;
    m_post_left = 0; m_trig = '0;
  endfunction

  function automatic void model_arm(input bit md, input logic [DW-1:0] tp);
    model_reset();
    m_armed = 1; m_busy = 1; m_mode = md; m_trig = tp;
  endfunction

  function automatic void model_commit(input entry_t e);
    logic [DW-1:0] pc;
    pc = e[EW-1 -: DW];
    if (!m_busy) return;
    mq.push_back(e);
    if (!m_mode) begin
      if (mq.size() == DEPTH) m_busy = 0;
    end else begin
      if (mq.size() > DEPTH) begin
        mq.delete(0);
        m_ovf = 1;
      end
      if (m_in_post) begin
        m_post_left--;
        if (m_post_left == 0) m_busy = 0;
      end else if (pc == m_trig) begin
        m_trg = 1;
        if (POST_TRIG == 0) m_busy = 0;
        else begin
          m_in_post = 1;
          m_post_left = POST_TRIG;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic [DW-1:0] pc, input bit v);
    commit_valid   = v;
    commit_pc      = pc;
    commit_instr   = $urandom;
    commit_wb_data = $urandom;
    commit_rwd     = AW'($urandom);
    if (v) model_commit({commit_pc, commit_instr, commit_wb_data, commit_rwd});
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic do_arm(input bit md, input logic [DW-1:0] tp, input bit cv);
    arm = 1'b1; mode = md; trig_pc = tp;
    commit_valid = cv; commit_pc = $urandom; commit_instr = $urandom;
    model_arm(md, tp);
    tick();
    arm = 1'b0; commit_valid = 1'b0; mode = $urandom_range(0, 1); trig_pc = $urandom;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 128'(count), 128'(mq.size()));
    chk({tag, "_busy"}, 128'(busy), 128'(m_busy));
    chk({tag, "_rd_valid"}, 128'(rd_valid), 128'(m_armed && !m_busy && mq.size() != 0));
    chk({tag, "_triggered"}, 128'(triggered), 128'(m_trg));
    chk({tag, "_overflow"}, 128'(overflow), 128'(m_ovf));
  endtask

  task automatic drain(input int stall_first, input bit rand_ready);
    int i = 0;
    while (rd_valid && i < 200) begin
      if (i < stall_first) rd_ready = 1'b0;
      else rd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      i++;
    end
    rd_ready = 1'b0;
    if (i >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: got rd_valid stuck expected drain done");
    end
    chk("drain_left", 128'(mq.size()), 128'(0));
    chk("drain_count", 128'(count), 128'(0));
  endtask

  // Monitor: scoreboard pop on handshake; rd_data must hold while stalled.
  entry_t held;
  bit     held_v = 0;
  always @(negedge clk) begin
    if (rst_n === 1'b1 && arm === 1'b0 && rd_valid === 1'b1) begin
      if (rd_ready) begin
        held_v = 0;
        if (mq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL pop_empty: got %0h expected no entry", rd_data);
        end else begin
          chk("rd_data", 128'(rd_data), 128'(mq.pop_front()));
        end
      end else begin
        if (held_v) chk("rd_hold", 128'(rd_data), 128'(held));
        held = rd_data;
        held_v = 1;
      end
    end else begin
      held_v = 0;
    end
  end

  initial begin
    logic [DW-1:0] base;
    rst_n = 1'b0; arm = 1'b0; mode = 1'b0; trig_pc = '0; rd_ready = 1'b0;
    commit_valid = 1'b1; commit_pc = 32'h10; commit_instr = '0; commit_wb_data = '0; commit_rwd = '0;
    model_reset();
    tick(); tick();
    rst_n = 1'b1; commit_valid = 1'b0;
    check_state("reset");

    // Linear fill: 10 commits offered, only the first 8 recorded.
    do_arm(1'b0, '0, 1'b0);
    for (int i = 0; i < 10; i++) commit(32'(i * 4), 1'b1);
    check_state("linear");
    chk("linear_first_pc", 128'(rd_data[EW-1 -: DW]), 128'(32'h0));
    drain(0, 1'b0);

    // Ring with trigger at 0x40 and two post commits.
    do_arm(1'b1, 32'h40, 1'b0);
    for (int i = 0; i <= 20; i++) commit(32'(i * 4), 1'b1);
    check_state("ring");
    chk("ring_first_pc", 128'(rd_data[EW-1 -: DW]), 128'(32'h2C));
    drain(0, 1'b0);

    // Stalled commits and backpressure during drain.
    do_arm(1'b0, '0, 1'b0);
    for (int i = 0; i < 16; i++) commit(32'($urandom), 1'(i % 2 == 0));
    check_state("stall");
    drain(3, 1'b1);

    // Arm collides with a commit, then with an in-flight drain.
    do_arm(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) commit(32'h100 + 32'(i * 4), 1'b1);
    check_state("coll_fill");
    rd_ready = 1'b1;
    tick(); tick();
    arm = 1'b1; mode = 1'b0; commit_valid = 1'b0;
    model_arm(1'b0, '0);
    tick();
    arm = 1'b0; rd_ready = 1'b0;
    check_state("coll_rearm");
    for (int i = 0; i < 8; i++) commit(32'h200 + 32'(i * 4), 1'b1);
    drain(1, 1'b1);

    // Ring that never triggers: keeps capturing, never drains.
    do_arm(1'b1, 32'hFFFF_FFF0, 1'b0);
    for (int i = 0; i < 20; i++) commit(32'(i * 4), 1'b1);
    check_state("notrig");

    // Reset in mid capture discards everything.
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
    check_state("midreset");

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      bit md;
      md = 1'($urandom_range(0, 1));
      base = 32'($urandom_range(0, 1000)) * 4;
      do_arm(md, base + 32'($urandom_range(0, 20)) * 4, 1'($urandom_range(0, 1)));
      for (int i = 0; i < 26; i++) commit(base + 32'(i * 4), 1'($urandom_range(0, 3) != 0));
      check_state("rand");
      if (!m_busy) drain($urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
